// File: rtl/gps_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gps_uart_pkg
//  Description : Shared definitions for the UART transmit arbiter: FSM state
//                encoding, default bit timing and the wrap-around index helper
//                used by the round-robin picker.
//  Revision    : 1.0  initial release
// ============================================================================
package gps_uart_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

    // Default baud timing of the attached uart_tx
    localparam int c_DEFAULT_CLKS_PER_BIT = 142;

    // A frame is 10 bit times; 12 leaves two bit times of slack before abort
    localparam int c_TIMEOUT_BITS         = 12;
    localparam int c_DEFAULT_TIMEOUT_CLKS = c_TIMEOUT_BITS * c_DEFAULT_CLKS_PER_BIT;

    // Fold an index in 0..2n-1 back into 0..n-1
    function automatic int wrap_index(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Searches the request vector
//                starting one position above the last grant, wrapping around,
//                and returns the first set index.
//  Ports       : i_req        request vector
//                i_last_grant index granted most recently
//                o_winner     selected index (valid when o_any_req is high)
//                o_any_req    at least one request bit is set
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick
    import gps_uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any_req
);

    always_comb begin
        int w_idx;
        w_idx     = 0;
        o_winner  = '0;
        o_any_req = |i_req;
        // Walk from the farthest offset back to the nearest one so the
        // closest set bit after the last grant is the final assignment.
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = wrap_index(int'(i_last_grant) + k, NUM_REQ);
            if (i_req[IDX_W'(w_idx)]) begin
                o_winner = IDX_W'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one uart_tx between NUM_REQ requesters. A round-robin
//                winner's byte is latched at grant, strobed into the UART for
//                one cycle, and the arbiter then waits for tx_done_in or a
//                per-byte timeout before returning to IDLE.
//  Ports       : clk_in, rst_in (async, active high)
//                en_in        allow new grants
//                req_in       level requests, data_in byte i at [8i+7:8i]
//                ack_out      one-cycle pulse when requester byte captured
//                done_out     one-cycle pulse when requester byte sent
//                tx_dv_out    strobe to uart_tx, tx_data_out byte to send
//                tx_active_in, tx_done_in  status from uart_tx
//                busy_out     high outside IDLE
//                timeout_out  one-cycle pulse on abort
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter
    import gps_uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT,
    parameter int TIMEOUT_CLKS = c_TIMEOUT_BITS * CLKS_PER_BIT
)(
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   en_in,
    input  logic [NUM_REQ-1:0]     req_in,
    input  logic [8*NUM_REQ-1:0]   data_in,
    output logic [NUM_REQ-1:0]     ack_out,
    output logic [NUM_REQ-1:0]     done_out,
    output logic                   tx_dv_out,
    output logic [7:0]             tx_data_out,
    input  logic                   tx_active_in,
    input  logic                   tx_done_in,
    output logic                   busy_out,
    output logic                   timeout_out
);

    localparam int                 c_IDX_W    = $clog2(NUM_REQ);
    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CLKS);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_REQ - 1);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || CLKS_PER_BIT < 1 || TIMEOUT_CLKS < 2) begin : g_param_check
            $error("uart_tx_arbiter: illegal parameter combination");
        end
    endgenerate

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [c_IDX_W-1:0]  r_winner;
    logic [c_IDX_W-1:0]  r_last_grant;
    logic [c_IDX_W-1:0]  w_pick;
    logic                w_any_req;
    logic [7:0]          w_pick_byte;
    logic [7:0]          r_data;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [NUM_REQ-1:0]  r_done;
    logic                r_timeout;
    logic                w_grant;
    logic                w_finish;
    logic                w_expire;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_pick (
        .i_req        (req_in),
        .i_last_grant (r_last_grant),
        .o_winner     (w_pick),
        .o_any_req    (w_any_req)
    );

    assign w_pick_byte = data_in[{w_pick, 3'b000} +: 8];

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_finish    = 1'b0;
        w_expire    = 1'b0;
        tx_dv_out   = 1'b0;
        ack_out     = '0;
        busy_out    = 1'b1;
        case (r_state)
            IDLE: begin
                busy_out = 1'b0;
                if (en_in && !tx_active_in && w_any_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                tx_dv_out         = 1'b1;
                ack_out[r_winner] = 1'b1;
                w_state_nxt       = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Completion wins over a coincident timeout terminal count
                if (tx_done_in) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_expire    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Grant capture, timeout counter and completion pulses
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_winner     <= '0;
            r_last_grant <= c_LAST_RST;
            r_data       <= 8'h00;
            r_cnt        <= '0;
            r_done       <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_done    <= '0;
            r_timeout <= 1'b0;
            if (w_grant) begin
                r_winner <= w_pick;
                r_data   <= w_pick_byte;
            end
            if (r_state == WAIT_DONE && !w_finish && !w_expire) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_finish) begin
                r_done[r_winner] <= 1'b1;
                r_last_grant     <= r_winner;
            end
            if (w_expire) begin
                r_timeout    <= 1'b1;
                r_last_grant <= r_winner;
            end
        end
    end

    assign tx_data_out = r_data;
    assign done_out    = r_done;
    assign timeout_out = r_timeout;

endmodule
`default_nettype wire
